// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a
// 2-entry instruction FIFO, with redirect flush and bus timeout.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instValid,
  output logic [31:0] instData,
  output logic [31:0] instPc,
  input  logic        instReady,
  output logic        busErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   pc;
  logic [31:0]   addr;
  logic          drop;
  logic [CW-1:0] cnt;
  logic [31:0]   fifo_data [2];
  logic [31:0]   fifo_pc   [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic redir_ok;
  logic redir_bad;
  logic resp;
  logic expire;
  logic push;
  logic pop;
  logic flush;
  logic issue;

  // Event decode; ERR ignores every bus and redirect input
  always_comb begin
    redir_ok  = redirect && (redirectPc[1:0] == 2'b00)
                && (state != ERR);
    redir_bad = redirect && (redirectPc[1:0] != 2'b00)
                && (state != ERR);
    resp      = (state == WAIT) && imemValid;
    expire    = (state == WAIT) && !imemValid
                && (cnt == CW'(TIMEOUT - 1));
    push      = resp && !drop && !redirect;
    pop       = instValid && instReady && !redirect;
    flush     = redir_ok || redir_bad || expire;
    issue     = (state == IDLE) && (state_nx == WAIT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: request only while the FIFO can absorb the reply
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (redir_bad)
          state_nx = ERR;
        else if (!redir_ok && (count < 2'd2))
          state_nx = WAIT;
      end
      WAIT: begin
        if (redir_bad)      state_nx = ERR;
        else if (imemValid) state_nx = IDLE;
        else if (expire)    state_nx = ERR;
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; the FIFO head is hidden whenever it is empty
  always_comb begin
    imemReq   = (state == WAIT);
    imemAddr  = addr;
    busErr    = (state == ERR);
    instValid = (state != ERR) && (count != 2'd0);
    instData  = instValid ? fifo_data[rd_ptr] : '0;
    instPc    = instValid ? fifo_pc[rd_ptr]   : '0;
  end

  // Fetch pc, latched request address, drop flag, wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      addr <= RESET_PC;
      drop <= 1'b0;
      cnt  <= '0;
    end else if (state != ERR) begin
      if (issue) begin
        addr <= pc;
        cnt  <= '0;
      end else if ((state == WAIT) && !imemValid) begin
        cnt <= cnt + CW'(1);
      end
      if (state == WAIT) begin
        if (imemValid)     drop <= 1'b0;
        else if (redirect) drop <= 1'b1;
      end
      if (redir_ok)  pc <= redirectPc;
      else if (push) pc <= pc + 32'd4;
    end
  end

  // Two-entry FIFO; a flush beats any push or pop that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imemData;
        fifo_pc[wr_ptr]   <= addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bus/redirect/decode driver with a
// queue-based scoreboard plus directed fetch-unit scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady = 1'b0;
  logic        busErr;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData),
    .redirect(redirect), .redirectPc(redirectPc),
    .instValid(instValid), .instData(instData),
    .instPc(instPc), .instReady(instReady),
    .busErr(busErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q[$];
  logic [31:0] seen[$];
  logic [31:0] reqs[$];
  logic [31:0] exp_pc = RPC;
  bit          busy = 0;
  bit          drop = 0;
  int          waited = 0;
  int          lat = 0;
  int          n_req = 0;

  int          cfg_lat = 0;
  int          cfg_rdy = 1;
  int          cfg_rpct = 0;
  bit          cfg_hold = 0;
  bit          cfg_junk = 0;
  bit          arm = 0;
  bit          arm_any = 0;
  logic [31:0] arm_match = '0;
  logic [31:0] arm_pc = '0;
  bit          fired = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] qq[$],
                                      input int i);
    if (i < qq.size()) return qq[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus, redirect and decode driver with the reference model
  always @(negedge clk) begin : drv
    bit          resp;
    bit          rd;
    logic [31:0] rp;
    if (rst) begin
      q.delete();
      exp_pc    = RPC;
      busy      = 0;
      drop      = 0;
      imemValid = 1'b0;
      redirect  = 1'b0;
      instReady = 1'b0;
    end else begin
      if (imemReq) begin
        if (!busy) begin
          busy   = 1;
          waited = 0;
          lat    = (cfg_lat < 0) ? int'($urandom_range(3, 0)) : cfg_lat;
          chk("req_addr", imemAddr, exp_pc);
          reqs.push_back(imemAddr);
          n_req++;
        end else begin
          waited++;
        end
      end
      resp = imemReq && busy && !cfg_hold && (waited >= lat);
      rd = 0;
      rp = $urandom;
      rp[1:0] = 2'b00;
      if ($urandom_range(3, 0) == 0)
        rp = 32'hFFFF_FFF0 | (rp & 32'h0000_000C);
      if (arm && (arm_any || (imemReq && imemAddr == arm_match))) begin
        rd    = 1;
        rp    = arm_pc;
        arm   = 0;
        fired = 1;
      end else if (cfg_rpct > 0 && $urandom_range(99, 0) < cfg_rpct) begin
        rd = 1;
      end
      imemValid = resp ||
        (cfg_junk && !imemReq && ($urandom_range(1, 0) == 1));
      imemData   = resp ? mem(imemAddr) : $urandom;
      redirect   = rd;
      redirectPc = rp;
      instReady  = (cfg_rdy == 2) ? 1'($urandom_range(1, 0))
                                  : (cfg_rdy != 0);
      if (resp) begin
        busy = 0;
        if (!rd && !drop) begin
          q.push_back(ent_t'({exp_pc, mem(exp_pc)}));
          exp_pc = exp_pc + 32'd4;
        end
        drop = 0;
      end
      if (rd) begin
        q.delete();
        exp_pc = rp;
        if (imemReq && !resp) drop = 1;
      end
    end
  end

  // Monitor: every consumed instruction must match the queue head
  always @(negedge clk) begin : mon
    ent_t e;
    #1;
    if (!rst && instValid && instReady && !redirect) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h expected none",
                 instPc);
      end else begin
        e = q.pop_front();
        chk("inst_pc", instPc, e.pc);
        chk("inst_data", instData, e.data);
        seen.push_back(instPc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    seen.delete();
    reqs.delete();
    n_req = 0;
  endtask

  task automatic wait_fired();
    int k;
    k = 0;
    while (!fired && k < 50) begin
      tick(1);
      k++;
    end
    chk("redirect_fired", 32'(fired), 32'd1);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (imemReq !== 1'b1 && k < 10) begin
      tick(1);
      k++;
    end
    chk("req_seen", 32'(imemReq), 32'd1);
  endtask

  initial begin : main
    int bad;
    int n;
    #1 rst = 1'b1;
    #2;
    chk("rst_imemReq", 32'(imemReq), 32'd0);
    chk("rst_imemAddr", imemAddr, RPC);
    chk("rst_instValid", 32'(instValid), 32'd0);
    chk("rst_instData", instData, 32'd0);
    chk("rst_instPc", instPc, 32'd0);
    chk("rst_busErr", 32'(busErr), 32'd0);

    // in-order fetch with 1-cycle bus
    cfg_lat = 0;
    cfg_rdy = 1;
    do_reset();
    tick(10);
    chk("seq0", qat(seen, 0), 32'h0);
    chk("seq1", qat(seen, 1), 32'h4);
    chk("seq2", qat(seen, 2), 32'h8);
    n_req = 0;
    tick(20);
    chk("throughput", 32'(n_req), 32'd10);
    chk("seq_busErr", 32'(busErr), 32'd0);

    // backpressure stops fetching at two entries
    cfg_rdy = 0;
    do_reset();
    tick(12);
    chk("bp_reqs", 32'(n_req), 32'd2);
    chk("bp_idle", 32'(imemReq), 32'd0);
    cfg_rdy = 1;
    tick(1);
    cfg_rdy = 0;
    tick(10);
    chk("bp_one_more", 32'(n_req), 32'd3);
    chk("bp_idle2", 32'(imemReq), 32'd0);
    cfg_rdy = 1;
    tick(10);

    // redirect while waiting for 0x8 drops its response
    cfg_lat   = 2;
    arm_any   = 0;
    arm_match = 32'h8;
    arm_pc    = 32'h100;
    fired     = 0;
    arm       = 1;
    do_reset();
    tick(30);
    chk("rd_seen0", qat(seen, 0), 32'h0);
    chk("rd_seen1", qat(seen, 1), 32'h4);
    chk("rd_seen2", qat(seen, 2), 32'h100);
    chk("rd_req2", qat(reqs, 2), 32'h8);
    chk("rd_req3", qat(reqs, 3), 32'h100);
    n = 0;
    foreach (seen[i]) if (seen[i] == 32'h8) n++;
    chk("rd_no_0x8", 32'(n), 32'd0);

    // misaligned redirect is terminal
    cfg_lat   = 0;
    arm_match = 32'h4;
    arm_pc    = 32'h102;
    fired     = 0;
    arm       = 1;
    do_reset();
    wait_fired();
    tick(1);
    chk("err_busErr", 32'(busErr), 32'd1);
    chk("err_imemReq", 32'(imemReq), 32'd0);
    chk("err_instValid", 32'(instValid), 32'd0);
    cfg_junk = 1;
    cfg_rpct = 30;
    cfg_rdy  = 2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (imemReq !== 1'b0 || instValid !== 1'b0 || busErr !== 1'b1)
        bad++;
    end
    chk("err_terminal", 32'(bad), 32'd0);
    cfg_junk = 0;
    cfg_rpct = 0;
    cfg_rdy  = 1;

    // bus timeout
    cfg_hold = 1;
    do_reset();
    wait_req();
    n = 0;
    while (busErr !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_req", 32'(imemReq), 32'd0);
    cfg_hold = 0;

    // pc wrap at the top of the address space
    arm_any = 1;
    arm_pc  = 32'hFFFF_FFF8;
    fired   = 0;
    arm     = 1;
    do_reset();
    wait_fired();
    reqs.delete();
    tick(12);
    chk("wrap0", qat(reqs, 0), 32'hFFFF_FFF8);
    chk("wrap1", qat(reqs, 1), 32'hFFFF_FFFC);
    chk("wrap2", qat(reqs, 2), 32'h0000_0000);
    arm_any = 0;

    // asynchronous reset in the middle of a request
    cfg_hold = 1;
    wait_req();
    #1 rst = 1'b1;
    #1;
    chk("arst_imemReq", 32'(imemReq), 32'd0);
    chk("arst_imemAddr", imemAddr, RPC);
    @(negedge clk);
    #3 rst = 1'b0;
    reqs.delete();
    cfg_hold = 0;
    tick(6);
    chk("arst_first_req", qat(reqs, 0), RPC);

    // randomized traffic
    cfg_lat  = -1;
    cfg_rdy  = 2;
    cfg_rpct = 5;
    do_reset();
    tick(3000);
    cfg_rpct = 0;
    cfg_rdy  = 1;
    tick(4);
    chk("rand_busErr", 32'(busErr), 32'd0);
    cfg_hold = 1;
    tick(10);
    chk("rand_drain_q", 32'(q.size()), 32'd0);
    chk("rand_drain_valid", 32'(instValid), 32'd0);
    cfg_hold = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles a request may wait for imemValid.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imemReq, output, 1 bit: instruction-bus request.
REQ-006 SHALL have port imemAddr, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port imemValid, input, 1 bit: the bus returns imemData this cycle.
REQ-008 SHALL have port imemData, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port redirect, input, 1 bit: branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirectPc, input, 32 bits: new fetch address, sampled when redirect=1.
REQ-011 SHALL have port instValid, output, 1 bit: the FIFO head is valid.
REQ-012 SHALL have port instData, output, 32 bits: instruction at the FIFO head.
REQ-013 SHALL have port instPc, output, 32 bits: address of instData.
REQ-014 SHALL have port instReady, input, 1 bit: decode consumes the head when instValid=1 and instReady=1.
REQ-015 SHALL have port busErr, output, 1 bit: sticky fetch error.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and ERR.
REQ-017 IDLE: SHALL go to WAIT and assert imemReq with imemAddr=pc when FIFO occupancy < 2 and the state is not ERR.
REQ-018 WAIT: SHALL hold imemReq=1 and a stable imemAddr until the cycle imemValid=1.
REQ-019 WAIT, imemValid=1: SHALL push {imemData, imemAddr} into the FIFO, set pc=pc+4 (mod 2^32, wrap from FFFF_FFFC to 0) and return to IDLE, with no other event that cycle.
REQ-020 SHALL allow at most one outstanding request; back-to-back fetches SHALL have 1 IDLE cycle between them, giving a throughput of 1 instruction per 2 cycles under 1-cycle bus latency.
REQ-021 The FIFO SHALL hold 2 entries; instValid SHALL be 1 whenever occupancy > 0; push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-022 SHALL never issue a request that could overflow the FIFO; a pushed instruction SHALL be visible on inst* the cycle after the imemValid edge.
REQ-023 redirect=1 with redirectPc[1:0]==0 SHALL flush the FIFO, set instValid=0 next cycle and set pc=redirectPc.
REQ-024 redirect=1 in IDLE SHALL cause the next request to use the new pc.
REQ-025 redirect=1 in WAIT SHALL set a drop flag; the pending request SHALL complete, and its response SHALL be discarded (no push, pc unchanged) before returning to IDLE.
REQ-026 redirect and imemValid in the same cycle SHALL discard that response, and redirect SHALL take priority.
REQ-027 redirect and a pop in the same cycle SHALL mean the flush wins.
REQ-028 redirect with redirectPc[1:0]!=0 SHALL set busErr=1, flush the FIFO and enter ERR.
REQ-029 WAIT: SHALL count cycles without imemValid; when the count reaches TIMEOUT with no response, it SHALL set busErr=1, drop imemReq and enter ERR.
REQ-030 ERR SHALL be terminal until rst: imemReq=0, instValid=0, busErr=1, and redirect and imemValid SHALL be ignored.

Reset
REQ-031 SHALL reset asynchronously on rst=1, independent of clk.
REQ-032 Reset values: state=IDLE, pc=RESET_PC, FIFO empty, drop=0, timeout counter=0.
REQ-033 Reset output values: imemReq=0, imemAddr=RESET_PC, instValid=0, instData=0, instPc=0, busErr=0.
REQ-034 rst asserted mid-WAIT SHALL abandon the request; the first request after release SHALL go to RESET_PC.

Verification
REQ-035 Reset, 1-cycle bus, instReady=1: expect fetches at 0x0, 0x4, 0x8 in order with instPc matching, and busErr=0.
REQ-036 instReady=0: expect exactly 2 fetches and then imemReq held 0; after instReady=1 for one cycle, expect exactly one new fetch.
REQ-037 redirect to 0x100 during WAIT for 0x8: expect the 0x8 data never to appear on inst*, and the next request at 0x100.
REQ-038 redirect to 0x102: expect busErr=1 the next cycle, imemReq=0 and instValid=0 from then on, until rst.
REQ-039 Hold imemValid=0 for TIMEOUT cycles: expect busErr=1 exactly TIMEOUT cycles after the request, and imemReq to drop.
REQ-040 pc at 0xFFFF_FFFC: expect the next fetch at 0x0000_0000, and rst pulsed mid-WAIT to restart the fetch at RESET_PC.
